// File: rtl/mem_access_stage.sv
// MEM stage: load/store transfers on a req/ready data bus, store lane steering, load extension.
// Optional misaligned-access trap enabled by MEM_STAGE_MISALIGN_TRAP_EN (adds the misalign port).
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] alu_in,
    input  logic [31:0] rs2_data_in,
    input  logic [2:0]  funct3_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [4:0]  rd_in,
    input  logic [31:0] pc4_in,
    input  logic [1:0]  mem_to_reg_in,
    input  logic        reg_write_in,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    output logic        misalign,
`endif
    output logic [31:0] alu,
    output logic [31:0] pc4,
    output logic [4:0]  rd,
    output logic [1:0]  mem_to_reg,
    output logic        reg_write,
    output logic [31:0] mem_rdata,
    output logic        stall,
    output logic        bus_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

    state_t           state_q, state_d;
    logic             req_q, req_d, we_q, we_d, bus_err_q, bus_err_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        access, mis_c;
    logic [1:0]  a;
    logic [3:0]  st_be;
    logic [31:0] st_wdata, ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign access = mem_read_in | mem_write_in;
    assign a      = alu_in[1:0];

    // Store lane steering; low address bits below the access size are ignored
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = rs2_data_in;
        if (mem_write_in) begin
            case (funct3_in[1:0])
                2'b00: begin
                    st_be    = 4'b0001 << a;
                    st_wdata = {4{rs2_data_in[7:0]}};
                end
                2'b01: begin
                    st_be    = a[1] ? 4'b1100 : 4'b0011;
                    st_wdata = {2{rs2_data_in[15:0]}};
                end
                default: begin
                    st_be    = 4'b1111;
                    st_wdata = rs2_data_in;
                end
            endcase
        end
    end

    // Load lane select and extension
    always_comb begin
        ld_byte = dmem_rdata[{a, 3'b000} +: 8];
        ld_half = a[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3_in)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = dmem_rdata;
        endcase
    end

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    assign mis_c = (state_q == IDLE) && access &&
                   (((funct3_in[1:0] == 2'b01) && a[0]) ||
                    ((funct3_in[1:0] == 2'b10) && (a != 2'b00)));
    assign misalign = mis_c;
`else
    assign mis_c = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        be_d      = be_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        rdata_d   = '0;
        bus_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (access && !mis_c) begin
                    addr_d  = {alu_in[31:2], 2'b00};
                    be_d    = st_be;
                    wdata_d = mem_write_in ? st_wdata : '0;
                    we_d    = mem_write_in;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (dmem_ready) begin
                    rdata_d = mem_write_in ? '0 : ld_data;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    bus_err_d = 1'b1;
                    req_d     = 1'b0;
                    we_d      = 1'b0;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            be_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            be_q      <= be_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            bus_err_q <= bus_err_d;
            cnt_q     <= cnt_d;
        end
    end

    // rdata_q is non-zero only in DONE, so it drives MEM/WB directly
    assign stall      = ((state_q == IDLE) && access && !mis_c) || (state_q == REQ);
    assign mem_rdata  = rdata_q;
    assign bus_err    = bus_err_q;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;

    assign alu        = alu_in;
    assign pc4        = pc4_in;
    assign rd         = rd_in;
    assign mem_to_reg = mem_to_reg_in;
    assign reg_write  = reg_write_in & ~mis_c;

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage RV32I pipeline, between the EX/MEM and MEM/WB pipeline registers.
- Runs load/store transfers on a req/ready data-memory bus.
- Generates store byte-enables and lane-replicated write data; aligns and sign/zero-extends load data.
- Stalls upstream while a transfer is outstanding; control fields pass through to MEM/WB.

Parameters:
- TIMEOUT, 16: max REQ-state cycles waiting for dmem_ready before abort; must be >= 1.
- CNT_W, 5: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- alu_in  in  32  effective address / ALU result from EX/MEM.
- rs2_data_in  in  32  store data.
- funct3_in  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- mem_read_in  in  1  load.
- mem_write_in  in  1  store.
- rd_in  in  5  destination register.
- pc4_in  in  32  PC+4.
- mem_to_reg_in  in  2  writeback select.
- reg_write_in  in  1  register write enable.
- alu, pc4  out  32  passthrough to MEM/WB.
- rd  out  5  passthrough.
- mem_to_reg  out  2  passthrough.
- reg_write  out  1  reg_write_in, gated by the optional misalign trap.
- mem_rdata  out  32  formatted load data to MEM/WB.
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- bus_err  out  1  one-cycle pulse on timeout.
- dmem_req, dmem_we  out  1  bus request, write qualifier.
- dmem_addr  out  32  word-aligned address, addr[1:0]=0.
- dmem_wdata  out  32  write data.
- dmem_be  out  4  byte enables.
- dmem_ready  in  1  slave completion.
- dmem_rdata  in  32  read word, valid when dmem_ready=1.

Behaviour:
- access = mem_read_in | mem_write_in. If both are set, treat it as a store and do not capture read data.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - If access: latch addr, be, wdata and we into registers, clear the counter, go to REQ.
  - If no access: stay in IDLE.
- REQ:
  - dmem_req=1, driven from a register.
  - If dmem_ready=1: capture dmem_rdata into rdata_q, go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without ready: rdata_q=0, bus_err=1 for one cycle, go to DONE.
- DONE: unconditionally go to IDLE.
- stall = (IDLE & access) | REQ, combinational. stall=0 in DONE so the same instruction, still held at the inputs, advances into MEM/WB on that edge.
- Minimum latency is 3 cycles per access (ready in the first REQ cycle). Back-to-back accesses: the next IDLE sees the next instruction.
- Non-memory instructions: no stall, mem_rdata=0. All passthrough outputs are combinational from the inputs.
- Load format, using a = addr[1:0] and the selected lane:
  - B: sign-extend byte a.
  - BU: zero-extend byte a.
  - H: sign-extend half a[1].
  - HU: zero-extend half a[1].
  - W: whole word.
  - mem_rdata is valid in DONE, 0 elsewhere.
- Store format:
  - SB: be = 0001<<a, wdata = {4{byte}}.
  - SH: be = 0011<<(2*a[1]), wdata = {2{half}}.
  - SW: be = 1111.
  - Loads drive be = 1111, we = 0.
- dmem_addr = {addr[31:2], 2'b00}; held stable throughout REQ.
- reset (asynchronous):
  - State = IDLE; all registered outputs = 0: dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, bus_err, rdata_q, counter.
  - Reset during REQ drops dmem_req immediately. The transfer is abandoned; a late dmem_ready is ignored.

Optional Feature:
- Macro: MEM_STAGE_MISALIGN_TRAP_EN.
- Misaligned means: H/HU/SH with a[0]=1, or W/SW with a≠0.
- Defined:
  - A misaligned access in IDLE does not enter REQ: stall=0, no bus request.
  - Output misalign (1 bit, added port) = 1 for that cycle.
  - reg_write is forced to 0.
- Undefined:
  - No misalign port.
  - The offending low address bits are dropped: H uses a[1] only; W uses addr[1:0]=0. The access is performed normally.

Test Plan:
- LW 0x100, dmem_ready on the 3rd REQ cycle with rdata 0xDEADBEEF -> stall high 4 cycles, dmem_addr 0x100, be 1111, we 0, mem_rdata 0xDEADBEEF in DONE.
- LB then LBU at 0x103 with rdata 0x80FF0000 -> mem_rdata 0xFFFFFF80 then 0x00000080. LH at 0x102 -> 0xFFFF80FF.
- SH 0x102 with rs2 0x1234ABCD, ready immediate -> be 1100, wdata 0xABCDABCD, we 1, stall 2 cycles.
- dmem_ready never asserted -> dmem_req high exactly 16 cycles, bus_err pulses once, mem_rdata 0, stall drops, then IDLE.
- reset asserted mid-REQ -> dmem_req 0 with no clock edge, FSM IDLE; a later dmem_ready is ignored.
- LW 0x101:
  - Macro defined -> misalign=1, reg_write=0, no dmem_req.
  - Macro undefined -> dmem_addr 0x100, normal load.
